// File: rtl/conv_frame_arbiter_pkg.sv
// Shared types and sizing helpers for the frame-granular convolution filter arbiter.
package conv_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } arb_state_t;

    typedef logic src_id_t;

    function automatic int frame_pixels(input int width, input int height);
        return width * height;
    endfunction

    function automatic int cnt_width(input int max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/conv_frame_arbiter_rr_arb2.sv
// Two-way round-robin picker; the pointer holds the source served last.
module rr_arb2
    import conv_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       last,
    input  src_id_t    owner,
    input  logic       enable,
    output logic [1:0] grant
);

    src_id_t ptr;

    // Pointer starts at src1 so that src0 wins the first tie after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b1;
        end else if (last) begin
            ptr <= owner;
        end
    end

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ptr ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/conv_frame_arbiter.sv
// Grants a shared 3x3 streaming filter one whole frame at a time and tags its output.
// Optional stall-timeout padding is enabled with the macro CONV_ARB_TIMEOUT_EN.
module conv_frame_arbiter
    import conv_arb_pkg::*;
#(
    parameter int IMAGE_WIDTH    = 320,
    parameter int IMAGE_HEIGHT   = 464,
    parameter int DATA_WIDTH     = 8,
    parameter int PIPE_LATENCY   = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  src0_valid,
    input  logic                  src1_valid,
    input  logic [DATA_WIDTH-1:0] src0_data,
    input  logic [DATA_WIDTH-1:0] src1_data,
    output logic                  src0_ready,
    output logic                  src1_ready,
    output logic                  filt_pixel_valid,
    output logic [DATA_WIDTH-1:0] filt_pixel_in,
    input  logic                  filt_out_valid,
    input  logic [DATA_WIDTH-1:0] filt_out,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_src,
    output logic                  out_sof,
    output logic                  out_eof,
    output logic [1:0]            grant,
    output logic                  busy,
`ifdef CONV_ARB_TIMEOUT_EN
    output logic                  timeout_err,
`endif
    output logic                  frame_done
);

    localparam int FP = frame_pixels(IMAGE_WIDTH, IMAGE_HEIGHT);
    localparam int CW = cnt_width(FP);
    localparam int DW = $clog2(PIPE_LATENCY + 2);
    localparam logic [CW-1:0] LAST_PIX = CW'(FP - 1);

    arb_state_t      state;
    logic [CW-1:0]   in_cnt;
    logic [CW-1:0]   out_cnt;
    logic [DW-1:0]   drain_cnt;
    logic [1:0]      pick;
    logic            accept;
    logic            frame_end;
    logic            padding;
    logic            err_spurious;
    logic            err_drain;
    src_id_t         owner;

    assign owner     = grant[1];
    assign busy      = (state != IDLE);
    assign frame_end = filt_out_valid && (state == DRAIN) && (out_cnt == LAST_PIX);

    rr_arb2 u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({req1, req0}),
        .last   (frame_end),
        .owner  (owner),
        .enable (state == IDLE),
        .grant  (pick)
    );

    always_comb begin
        src0_ready = 1'b0;
        src1_ready = 1'b0;
        if (state == STREAM && !padding) begin
            src0_ready = grant[0];
            src1_ready = grant[1];
        end
        accept           = (src0_ready && src0_valid) || (src1_ready && src1_valid);
        filt_pixel_valid = accept || padding;
        filt_pixel_in    = '0;
        if (accept) begin
            filt_pixel_in = grant[1] ? src1_data : src0_data;
        end
    end

`ifdef CONV_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] stall_cnt;
`else
    assign padding = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            grant        <= 2'b00;
            in_cnt       <= '0;
            out_cnt      <= '0;
            drain_cnt    <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_src      <= 1'b0;
            out_sof      <= 1'b0;
            out_eof      <= 1'b0;
            frame_done   <= 1'b0;
            err_spurious <= 1'b0;
            err_drain    <= 1'b0;
`ifdef CONV_ARB_TIMEOUT_EN
            padding      <= 1'b0;
            stall_cnt    <= '0;
            timeout_err  <= 1'b0;
`endif
        end else begin
            out_valid  <= filt_out_valid;
            out_sof    <= filt_out_valid && (out_cnt == '0);
            out_eof    <= filt_out_valid && (out_cnt == LAST_PIX);
            out_src    <= filt_out_valid && owner;
            frame_done <= frame_end;
`ifdef CONV_ARB_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            // Output tagging runs in every state; ownerless output is flagged, not dropped.
            if (filt_out_valid) begin
                out_data <= filt_out;
                if (state != IDLE) begin
                    out_cnt <= out_cnt + 1'b1;
                end else if (out_cnt == '0) begin
                    err_spurious <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (pick != 2'b00) begin
                        grant     <= pick;
                        state     <= STREAM;
                        in_cnt    <= '0;
                        out_cnt   <= '0;
                        drain_cnt <= '0;
`ifdef CONV_ARB_TIMEOUT_EN
                        stall_cnt <= '0;
`endif
                    end
                end
                STREAM: begin
`ifdef CONV_ARB_TIMEOUT_EN
                    if (!padding) begin
                        if (accept) begin
                            stall_cnt <= '0;
                        end else if (stall_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                            padding     <= 1'b1;
                            timeout_err <= 1'b1;
                        end else begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
                    end
`endif
                    if (filt_pixel_valid) begin
                        in_cnt <= in_cnt + 1'b1;
                        if (in_cnt == LAST_PIX) begin
                            state <= DRAIN;
`ifdef CONV_ARB_TIMEOUT_EN
                            padding <= 1'b0;
`endif
                        end
                    end
                end
                DRAIN: begin
                    // The tail of the frame must emerge within the filter latency.
                    if (frame_end) begin
                        state     <= IDLE;
                        grant     <= 2'b00;
                        out_cnt   <= '0;
                        drain_cnt <= '0;
                    end else if (drain_cnt == DW'(PIPE_LATENCY)) begin
                        err_drain <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_frame_arbiter.sv
// Scoreboarded directed bench for conv_frame_arbiter with a 4-cycle filter model.
module tb_conv_frame_arbiter;

    localparam int W    = 8;
    localparam int H    = 6;
    localparam int NPIX = W * H;

    typedef struct packed {
        logic [7:0] d;
        logic       s;
        logic       sof;
        logic       eof;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       req0, req1;
    logic       src0_valid, src1_valid;
    logic [7:0] src0_data, src1_data;
    logic       src0_ready, src1_ready;
    logic       filt_pixel_valid;
    logic [7:0] filt_pixel_in;
    logic       filt_out_valid;
    logic [7:0] filt_out;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_src, out_sof, out_eof;
    logic [1:0] grant;
    logic       busy;
    logic       frame_done;
`ifdef CONV_ARB_TIMEOUT_EN
    logic       timeout_err;
`endif

    int   checks   = 0;
    int   failures = 0;
    int   fpv_cnt  = 0;
    int   out_seen = 0;
    exp_t sb[$];

    conv_frame_arbiter #(
        .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .DATA_WIDTH(8),
        .PIPE_LATENCY(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .src0_valid(src0_valid), .src1_valid(src1_valid),
        .src0_data(src0_data), .src1_data(src1_data),
        .src0_ready(src0_ready), .src1_ready(src1_ready),
        .filt_pixel_valid(filt_pixel_valid), .filt_pixel_in(filt_pixel_in),
        .filt_out_valid(filt_out_valid), .filt_out(filt_out),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_sof(out_sof), .out_eof(out_eof), .grant(grant), .busy(busy),
`ifdef CONV_ARB_TIMEOUT_EN
        .timeout_err(timeout_err),
`endif
        .frame_done(frame_done)
    );

    // Filter model: fixed 4-cycle latency, output = input ^ 0x5A.
    logic [3:0] fv;
    logic [7:0] fd0, fd1, fd2, fd3;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fv <= '0;
            fd0 <= '0; fd1 <= '0; fd2 <= '0; fd3 <= '0;
        end else begin
            fv  <= {fv[2:0], filt_pixel_valid};
            fd0 <= filt_pixel_in ^ 8'h5A;
            fd1 <= fd0;
            fd2 <= fd1;
            fd3 <= fd2;
        end
    end
    assign filt_out_valid = fv[3];
    assign filt_out       = fd3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (filt_pixel_valid) fpv_cnt++;
                chk("ready_only_granted", 32'({src1_ready, src0_ready} & ~grant), 0);
                if (out_valid) begin
                    out_seen++;
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", out_data, e.d);
                        chk("out_src", out_src, e.s);
                        chk("out_sof", out_sof, e.sof);
                        chk("out_eof", out_eof, e.eof);
                        chk("frame_done_at_eof", frame_done, e.eof);
                    end
                end else begin
                    chk("frame_done_quiet", frame_done, 0);
                end
            end
        end
    endtask

    task automatic wait_grant(input string tag, input logic [1:0] exp);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant == 2'b00 && n < 20);
        chk(tag, grant, exp);
    endtask

    task automatic feed(input int src, input int gap_pct, input int stop_at, input int drop_at);
        int k = 0;
        int cyc = 0;
        logic v;
        logic [7:0] d;
        exp_t e;
        @(posedge clk); #1;
        while (k < stop_at && cyc < 1000) begin
            v = ($urandom_range(0, 99) >= gap_pct);
            d = 8'($urandom);
            if (src == 0) begin src0_valid = v; src0_data = d; end
            else          begin src1_valid = v; src1_data = d; end
            @(negedge clk);
            if (v && (src == 0 ? src0_ready : src1_ready)) begin
                chk("filt_pixel_valid", filt_pixel_valid, 1);
                chk("filt_pixel_in", filt_pixel_in, d);
                e.d = d ^ 8'h5A;
                e.s = src[0];
                e.sof = (k == 0);
                e.eof = (k == NPIX - 1);
                sb.push_back(e);
                k++;
                if (k == drop_at) begin
                    if (src == 0) req0 = 1'b0;
                    else          req1 = 1'b0;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        src0_valid = 1'b0;
        src1_valid = 1'b0;
        chk("feed_accepted", k, stop_at);
    endtask

    task automatic wait_frame_done(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 400);
        chk({tag, "_frame_done"}, frame_done, 1);
        chk({tag, "_grant_clear"}, grant, 0);
        chk({tag, "_busy_clear"}, busy, 0);
    endtask

    task automatic check_counts(input string tag);
        @(negedge clk);
        chk({tag, "_pixels_in"}, fpv_cnt, NPIX);
        chk({tag, "_pixels_out"}, out_seen, NPIX);
        chk({tag, "_sb_empty"}, sb.size(), 0);
        fpv_cnt  = 0;
        out_seen = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        fpv_cnt  = 0;
        out_seen = 0;
    endtask

    initial begin
`ifdef CONV_ARB_TIMEOUT_EN
        int n;
        int pads;
        exp_t e;
`endif
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        src0_valid = 1'b0; src1_valid = 1'b0;
        src0_data = '0; src1_data = '0;
        fork monitor(); join_none

        repeat (3) @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_filt_valid", filt_pixel_valid, 0);
        chk("rst_src0_ready", src0_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single source, back-to-back pixels.
        req0 = 1'b1;
        wait_grant("t1_grant", 2'b01);
        feed(0, 0, NPIX, 1);
        wait_frame_done("t1");
        check_counts("t1");

        // Both requesting from reset: src0 first, then src1.
        rst_n = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        do_reset();
        wait_grant("t2_first_grant", 2'b01);
        src1_valid = 1'b1;
        feed(0, 0, NPIX, 5);
        wait_frame_done("t2a");
        check_counts("t2a");
        chk("t2_second_grant", grant, 2'b10);
        src0_valid = 1'b1;
        src0_data  = 8'hC3;
        feed(1, 0, NPIX, 5);
        wait_frame_done("t2b");
        check_counts("t2b");

        // Random 50% gaps on src0.
        req0 = 1'b1;
        wait_grant("t3_grant", 2'b01);
        feed(0, 50, NPIX, 1);
        wait_frame_done("t3");
        check_counts("t3");

        // req0 dropped after 10 pixels while req1 waits.
        req0 = 1'b1;
        wait_grant("t4_grant", 2'b01);
        req1 = 1'b1;
        feed(0, 0, NPIX, 10);
        wait_frame_done("t4a");
        check_counts("t4a");
        chk("t4_next_grant", grant, 2'b10);
        feed(1, 0, NPIX, 1);
        wait_frame_done("t4b");
        check_counts("t4b");

        // Reset in the middle of a frame, then a clean frame.
        req0 = 1'b1;
        wait_grant("t5_grant", 2'b01);
        feed(0, 0, 20, 0);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("t5_rst_grant", grant, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_out_valid", out_valid, 0);
        chk("t5_rst_filt_valid", filt_pixel_valid, 0);
        chk("t5_rst_src0_ready", src0_ready, 0);
        chk("t5_rst_frame_done", frame_done, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        fpv_cnt  = 0;
        out_seen = 0;
        wait_grant("t5_regrant", 2'b01);
        feed(0, 0, NPIX, 1);
        wait_frame_done("t5");
        check_counts("t5");

`ifdef CONV_ARB_TIMEOUT_EN
        // Source stalls after 30 pixels; the arbiter pads the rest with zeros.
        req0 = 1'b1;
        wait_grant("t6_grant", 2'b01);
        feed(0, 0, 30, 1);
        for (int k = 30; k < NPIX; k++) begin
            e.d = 8'h5A;
            e.s = 1'b0;
            e.sof = 1'b0;
            e.eof = (k == NPIX - 1);
            sb.push_back(e);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (timeout_err !== 1'b1 && n < 40);
        chk("t6_timeout_cycle", n, 17);
        pads = 0;
        while (filt_pixel_valid && pads < 40) begin
            chk("t6_pad_data", filt_pixel_in, 0);
            chk("t6_pad_ready", src0_ready, 0);
            pads++;
            @(negedge clk);
        end
        chk("t6_pad_count", pads, NPIX - 30);
        wait_frame_done("t6");
        check_counts("t6");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
